mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-memory port. It arbitrates requests, sequences each memory transaction with a req/valid handshake and returns a one-cycle ack with registered read data. It also raises a stall to freeze the pipeline banks while either port waits. Data requests have priority, and a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 10, word address width (matches iaddr/daddr)
DATA_W, 32, data bus width
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win
TIMEOUT, 16, bus-state cycles without mem_valid before the transaction is aborted

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous reset, active-high
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction, valid with i_ack
i_ack  out  1  one-cycle fetch completion
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid with d_ack
d_ack  out  1  one-cycle data completion
mem_req  out  1  memory transaction active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_valid  in  1  memory completion strobe
err  out  1  one-cycle pulse on timeout abort
stall  out  1  pipeline freeze

Behaviour:
- Reset: state IDLE, starve_cnt=0, timer=0; all outputs 0, including rdata regs. Asynchronous reset, active-high. Reset mid-transaction abandons it with no ack.
- FSM states: IDLE, BUS_I, BUS_D, RESP.
- IDLE arbitration:
  - d_req and not i_req -> BUS_D.
  - i_req and not d_req -> BUS_I.
  - Both: BUS_D if starve_cnt<STARVE_MAX, else BUS_I.
  - Neither: stay.
- Starvation counter: increments (saturating) when both request and data wins; clears on any BUS_I entry.
- Grant latch: on entry to BUS_x, register addr/we/wdata from the winner (we=0 for fetch). Requester changes during BUS_x are ignored.
- BUS_x:
  - mem_req=1, mem_* drive latched values.
  - timer increments each cycle.
  - mem_valid=1 -> capture mem_rdata into owner's rdata reg (reads only; writes leave d_rdata unchanged) -> RESP.
  - timer reaches TIMEOUT-1 without mem_valid -> rdata reg=0, err=1 for the RESP cycle -> RESP.
- RESP: owner's ack=1 for exactly this cycle; mem_req=0; no arbitration; timer cleared; -> IDLE. Requesters drop req in the cycle after ack, so no double grant.
- Latency: request seen in IDLE at cycle 0; mem_req from cycle 1; mem_valid at cycle k (k>=1); ack at k+1. Minimum is 3 cycles per access (ack at cycle 2).
- mem_valid outside BUS_x is ignored.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- i_ack and d_ack are never high together.
- A new request from the port just served is arbitrated normally in the following IDLE.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, BUS_I, BUS_D, RESP};
  - typedef owner_t (FETCH/DATA);
  - default constants for STARVE_MAX and TIMEOUT.
- No sub-module; a single module.

Test Plan:
1. Fetch only, i_addr=0x004, mem_valid 1 cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x004, mem_we=0, i_ack at cycle 2, i_rdata=0x00500093, stall high cycles 0-1.
2. Data write d_addr=0x010, d_wdata=0xDEADBEEF, d_we=1, mem_valid after 3 cycles -> mem_we=1, mem_wdata=0xDEADBEEF, d_ack at cycle 5, d_rdata unchanged.
3. i_req and d_req both held, each transaction answered in 1 cycle -> data granted 4 times (STARVE_MAX=4), then fetch granted; sequence D,D,D,D,I repeating.
4. Both requests arrive in the same cycle -> BUS_D first, then BUS_I; acks are never simultaneous.
5. mem_valid never asserted -> err pulse and d_ack with d_rdata=0 at cycle 17 (TIMEOUT=16), then IDLE.
6. RESET asserted mid BUS_D -> all outputs 0 immediately, no ack; after release, a pending i_req is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory, with data
// priority, fetch starvation protection and a bus timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              err,
  output logic              stall
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned TM_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state, state_d;
  logic [SC_W-1:0]   starve_cnt;
  logic [TM_W-1:0]   timer;
  logic              grant_i, grant_d;
  logic              done_ok, done_to;
  owner_t            owner;

  assign owner = (state == BUS_D) ? DATA : FETCH;
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Next-state: arbitration in IDLE, completion or timeout in the bus states.
  always_comb begin
    state_d = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || (starve_cnt < SC_W'(STARVE_MAX)))) begin
          state_d = BUS_D;
          grant_d = 1'b1;
        end else if (i_req) begin
          state_d = BUS_I;
          grant_i = 1'b1;
        end
      end
      BUS_I, BUS_D: begin
        if (mem_valid) begin
          state_d = RESP;
          done_ok = 1'b1;
        end else if (timer == TM_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          done_to = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Grant latch, timer, starvation counter and registered responses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt <= '0;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;

      if (grant_i || grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
      end

      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && i_req && (starve_cnt < SC_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end

      if ((state == BUS_I || state == BUS_D) && !(done_ok || done_to)) begin
        timer <= timer + TM_W'(1);
      end else begin
        timer <= '0;
      end

      if (done_ok || done_to) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        i_ack   <= (owner == FETCH);
        d_ack   <= (owner == DATA);
        err     <= done_to;
        if (owner == FETCH) begin
          i_rdata <= done_to ? '0 : mem_rdata;
        end else if (done_to) begin
          d_rdata <= '0;
        end else if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard of
// expected acks, and hand sequences for starvation, collisions and reset.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_req, d_req, d_we, mem_valid;
  logic [9:0]  i_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic        i_ack, d_ack, mem_req, mem_we, err, stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  int          lat = 1;
  bit          stray = 1'b0;
  int          bus_cyc = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_i = '0;
  logic [31:0] model_d = '0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          lat;
    int          cyc;
  } vec_t;
  vec_t vecs[8];

  mem_port_arbiter dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .err       (err),
    .stall     (stall)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit we, input logic [9:0] addr, input int l);
    exp_t e;
    e.is_d = is_d;
    e.err  = (l == 0);
    if (l == 0)           e.rdata = '0;
    else if (is_d && we)  e.rdata = model_d;
    else                  e.rdata = mem[addr];
    if (is_d) model_d = e.rdata;
    else      model_i = e.rdata;
    sb.push_back(e);
  endtask

  // Memory responder: mem_valid on the lat-th cycle of mem_req (lat=0 never).
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem_req) bus_cyc++;
      else         bus_cyc = 0;
      mem_valid = stray || (mem_req && lat != 0 && bus_cyc == lat);
      mem_rdata = mem[mem_addr];
      if (mem_valid && mem_req && mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Ack monitor: pops the scoreboard on every completion.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET && (i_ack || d_ack)) begin
        check("ack_exclusive", 32'(i_ack & d_ack), 32'(0));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b with empty scoreboard", i_ack, d_ack);
        end else begin
          e = sb.pop_front();
          check("ack_port", 32'(d_ack), 32'(e.is_d));
          check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
          check("err_on_ack", 32'(err), 32'(e.err));
        end
      end else if (!RESET && err) begin
        check("err_without_ack", 32'(err), 32'(0));
      end
    end
  end

  task automatic do_txn(input vec_t v);
    int n;
    bit seen;
    @(posedge CLK);
    #1;
    lat = v.lat;
    push_exp(v.is_d, v.we, v.addr, v.lat);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    check("stall_req", 32'(stall), 32'(1));
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 1) begin
        check("mem_req_c1", 32'(mem_req), 32'(1));
        check("mem_addr", 32'(mem_addr), 32'(v.addr));
        check("mem_we", 32'(mem_we), 32'(v.is_d & v.we));
        check("stall_wait", 32'(stall), 32'(1));
        if (v.is_d) check("mem_wdata", mem_wdata, v.wdata);
      end
      if (i_ack || d_ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack within 40 cycles for addr 0x%03h", v.addr);
    end else begin
      check("ack_cycle", 32'(n), 32'(v.cyc));
      check("stall_ack", 32'(stall), 32'(0));
      check("mem_req_resp", 32'(mem_req), 32'(0));
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit di, dd;
    RESET = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[4] = 32'h00500093;

    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 10'h004, wdata: 32'h0,        lat: 1,  cyc: 2};
    vecs[1] = '{is_d: 1'b1, we: 1'b0, addr: 10'h000, wdata: 32'h0,        lat: 3,  cyc: 4};
    vecs[2] = '{is_d: 1'b1, we: 1'b1, addr: 10'h010, wdata: 32'hDEADBEEF, lat: 4,  cyc: 5};
    vecs[3] = '{is_d: 1'b1, we: 1'b0, addr: 10'h010, wdata: 32'h0,        lat: 2,  cyc: 3};
    vecs[4] = '{is_d: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        lat: 1,  cyc: 2};
    vecs[5] = '{is_d: 1'b1, we: 1'b0, addr: 10'h020, wdata: 32'h0,        lat: 0,  cyc: 17};
    vecs[6] = '{is_d: 1'b0, we: 1'b0, addr: 10'h008, wdata: 32'h0,        lat: 16, cyc: 17};
    vecs[7] = '{is_d: 1'b0, we: 1'b0, addr: 10'h00C, wdata: 32'h0,        lat: 0,  cyc: 17};

    // Reset state
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", mem_wdata, 32'(0));
    check("rst_acks", 32'({i_ack, d_ack, err}), 32'(0));
    check("rst_i_rdata", i_rdata, 32'(0));
    check("rst_d_rdata", d_rdata, 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    RESET = 1'b0;

    for (int k = 0; k < 8; k++) do_txn(vecs[k]);

    // mem_valid while idle must not produce a response
    @(negedge CLK);
    stray = 1'b1;
    @(negedge CLK);
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check("stray_idle", 32'({mem_req, i_ack, d_ack, err}), 32'(0));
    end

    // Both held: D,D,D,D,I twice
    @(posedge CLK);
    #1;
    lat = 1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, 10'h200, 1);
      push_exp(1'b0, 1'b0, 10'h100, 1);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
    i_req = 1'b1; i_addr = 10'h100;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(posedge CLK);
      #1;
      if (i_ack || d_ack) n++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("starve_ack_count", 32'(n), 32'(10));

    // Simultaneous arrival: data first, then fetch
    @(posedge CLK);
    #1;
    push_exp(1'b1, 1'b0, 10'h200, 1);
    push_exp(1'b0, 1'b0, 10'h100, 1);
    d_req = 1'b1; i_req = 1'b1;
    dd = 1'b0; di = 1'b0;
    for (int c = 0; c < 40 && !(dd && di); c++) begin
      @(posedge CLK);
      #1;
      if (d_ack) begin dd = 1'b1; d_req = 1'b0; end
      if (i_ack) begin di = 1'b1; i_req = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("collide_both_done", 32'({dd, di}), 32'(2'b11));

    // Reset in the middle of a data transaction
    @(posedge CLK);
    #1;
    lat = 0;
    push_exp(1'b1, 1'b0, 10'h030, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
    end
    check("busd_mem_req", 32'(mem_req), 32'(1));
    #2;
    RESET = 1'b1;
    d_req = 1'b0;
    i_req = 1'b1;
    i_addr = 10'h004;
    sb.delete();
    model_i = '0;
    model_d = '0;
    #1;
    check("midrst_outputs", 32'({mem_req, mem_we, i_ack, d_ack, err}), 32'(0));
    check("midrst_i_rdata", i_rdata, 32'(0));
    check("midrst_d_rdata", d_rdata, 32'(0));
    check("midrst_mem_addr", 32'(mem_addr), 32'(0));
    check("midrst_stall", 32'(stall), 32'(1));
    @(posedge CLK);
    @(posedge CLK);
    #1;
    lat = 1;
    push_exp(1'b0, 1'b0, 10'h004, 1);
    RESET = 1'b0;
    n = 0;
    di = 1'b0;
    while (!di && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
      if (i_ack) di = 1'b1;
    end
    i_req = 1'b0;
    check("post_rst_ack_cycle", 32'(n), 32'(2));

    repeat (3) @(posedge CLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
